// File: rtl/prirv32_pkg.sv
// prirv32_pkg: shared types and constants for the prirv32 fetch front end.
package prirv32_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sequential word address; wraps naturally at 2^32.
  function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  // Fetches are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/prirv32_fetch_buf.sv
// prirv32_fetch_buf: 2-entry FIFO of {pc, instr} between fetch and decode.
// When empty the head reads as a NOP at pc 0 so the decoder sees quiet values.
module prirv32_fetch_buf
  import prirv32_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         clear,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (cnt_q != 2'd2);
  assign do_pop  = pop && (cnt_q != 2'd0);

  // Storage, pointers and occupancy; clear empties the queue and beats push/pop.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem[0] <= {32'h0, INSTR_NOP};
      mem[1] <= {32'h0, INSTR_NOP};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign count = cnt_q;
  assign head  = (cnt_q == 2'd0) ? {32'h0, INSTR_NOP} : mem[rd_ptr];

endmodule

// File: rtl/prirv32_fetch_ctrl.sv
// prirv32_fetch_ctrl: fetch sequencer owning the PC and the instruction-memory
// port. One outstanding request at a time; returned words are queued for decode.
// Optional macro PRIRV32_FETCH_PERF_EN adds fetched/flushed event counters.
module prirv32_fetch_ctrl
  import prirv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        fetch_en_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
`ifdef PRIRV32_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_flushed_o
`endif
);

  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  req_pc_q;
  logic [1:0]   buf_count;
  logic [1:0]   count_next;
  fetch_entry_t head;
  logic         granted;
  logic         push;
  logic         pop;
  logic         drop_rsp;
  logic         issue_ok;

  assign granted    = (state_q == REQ) && imem_gnt_i;
  assign push       = (state_q == WAIT) && imem_rvalid_i && !redirect_i;
  assign pop        = instr_valid_o && instr_ready_i;
  assign drop_rsp   = imem_rvalid_i &&
                      ((state_q == FLUSH) || ((state_q == WAIT) && redirect_i));
  assign count_next = redirect_i ? 2'd0 : (buf_count + {1'b0, push} - {1'b0, pop});
  assign issue_ok   = fetch_en_i && (count_next < DEPTH);

  // Next-state: a redirect that catches a live request turns it into a flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!redirect_i && issue_ok) state_d = REQ;
      REQ:   if (imem_gnt_i) state_d = redirect_i ? FLUSH : WAIT;
      WAIT: begin
        if (imem_rvalid_i)   state_d = issue_ok ? REQ : IDLE;
        else if (redirect_i) state_d = FLUSH;
      end
      FLUSH: if (imem_rvalid_i) state_d = issue_ok ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, fetch PC and the PC of the request currently in flight.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (redirect_i) begin
        fetch_pc_q <= align_pc(redirect_pc_i);
      end else if (granted) begin
        fetch_pc_q <= next_fetch_pc(fetch_pc_q);
      end
      if (granted) begin
        req_pc_q <= fetch_pc_q;
      end
    end
  end

  prirv32_fetch_buf u_buf (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push       (push),
    .push_entry ({req_pc_q, imem_rdata_i}),
    .pop        (pop),
    .clear      (redirect_i),
    .count      (buf_count),
    .head       (head)
  );

  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = (buf_count != 2'd0);
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

`ifdef PRIRV32_FETCH_PERF_EN
  // Event counters: queued words, and words discarded by flushes or redirects.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      perf_fetched_o <= 32'd0;
      perf_flushed_o <= 32'd0;
    end else begin
      perf_fetched_o <= perf_fetched_o + {31'd0, push};
      perf_flushed_o <= perf_flushed_o + {31'd0, drop_rsp}
                        + (redirect_i ? {30'd0, buf_count} : 32'd0);
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop_rsp;
`endif

endmodule

// File: tb/tb_prirv32_fetch_ctrl.sv
// tb_prirv32_fetch_ctrl: directed vector table, hand-written redirect/reset
// sequences and a randomized run against a queue-based reference model.
module tb_prirv32_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_in;
  logic        rst_in;
  logic        fetch_en_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  logic        w_en;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_gnt;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

`ifdef PRIRV32_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
  logic [31:0] w_perf_fetched;
  logic [31:0] w_perf_flushed;
`endif

  int checks = 0;
  int errors = 0;

  prirv32_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .fetch_en_i    (fetch_en_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
`ifdef PRIRV32_FETCH_PERF_EN
    ,
    .perf_fetched_o (perf_fetched),
    .perf_flushed_o (perf_flushed)
`endif
  );

  prirv32_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .fetch_en_i    (w_en),
    .imem_req_o    (w_req),
    .imem_addr_o   (w_addr),
    .imem_gnt_i    (w_gnt),
    .imem_rvalid_i (w_rvalid),
    .imem_rdata_i  (w_rdata),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .instr_valid_o (w_valid),
    .instr_o       (w_instr),
    .instr_pc_o    (w_pc),
    .instr_ready_i (1'b1)
`ifdef PRIRV32_FETCH_PERF_EN
    ,
    .perf_fetched_o (w_perf_fetched),
    .perf_flushed_o (w_perf_flushed)
`endif
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } m_entry_t;

  m_entry_t    mq[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_inflight_pc;
  bit          m_req;
  bit          m_inflight;
  bit          m_stale;

  task automatic modelReset(input logic [31:0] rpc);
    mq.delete();
    m_fetch_pc    = rpc;
    m_inflight_pc = rpc;
    m_req         = 0;
    m_inflight    = 0;
    m_stale       = 0;
  endtask

  task automatic modelStep(input bit en, input bit gnt, input bit rv, input logic [31:0] rd,
                           input bit redir, input logic [31:0] rpc, input bit rdy);
    bit pop;
    bit may_issue;
    pop = (mq.size() > 0) && rdy;
    may_issue = 0;
    if (redir) begin
      mq.delete();
      if (m_req && gnt) begin
        m_req = 0; m_inflight = 1; m_stale = 1;
      end else if (m_inflight && rv) begin
        m_inflight = 0; m_stale = 0; may_issue = 1;
      end else if (m_inflight) begin
        m_stale = 1;
      end
      m_fetch_pc = {rpc[31:2], 2'b00};
    end else begin
      if (m_req && gnt) begin
        m_req = 0; m_inflight = 1;
        m_inflight_pc = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end else if (m_inflight && rv) begin
        if (!m_stale) mq.push_back({m_inflight_pc, rd});
        m_inflight = 0; m_stale = 0; may_issue = 1;
      end else if (!m_req && !m_inflight) begin
        may_issue = 1;
      end
      if (pop) void'(mq.pop_front());
    end
    if (may_issue && en && mq.size() < 2) m_req = 1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input bit e_req, input logic [31:0] e_addr,
                             input bit e_valid, input logic [31:0] e_instr,
                             input logic [31:0] e_pc);
    checkVal({tag, ".req"},   {31'd0, imem_req_o},    {31'd0, e_req});
    checkVal({tag, ".addr"},  imem_addr_o,            e_addr);
    checkVal({tag, ".valid"}, {31'd0, instr_valid_o}, {31'd0, e_valid});
    checkVal({tag, ".instr"}, instr_o,                e_instr);
    checkVal({tag, ".pc"},    instr_pc_o,             e_pc);
  endtask

  task automatic checkModel(input string tag);
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    e_instr = NOP;
    e_pc    = 32'h0;
    if (mq.size() > 0) begin
      e_instr = mq[0].instr;
      e_pc    = mq[0].pc;
    end
    checkOutput(tag, m_req, m_fetch_pc, mq.size() > 0, e_instr, e_pc);
  endtask

  // Drive one cycle's inputs just after the edge, then move to mid-cycle.
  task automatic applyStimulus(input bit en, input bit gnt, input bit rv, input logic [31:0] rd,
                               input bit redir, input logic [31:0] rpc, input bit rdy);
    fetch_en_i    = en;
    imem_gnt_i    = gnt;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    instr_ready_i = rdy;
    #4;
  endtask

  task automatic advance();
    modelStep(fetch_en_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
              redirect_i, redirect_pc_i, instr_ready_i);
    @(posedge clk_in);
    #1;
  endtask

  task automatic stepSeq(input string tag, input bit en, input bit gnt, input bit rv,
                         input logic [31:0] rd, input bit redir, input logic [31:0] rpc,
                         input bit rdy);
    applyStimulus(en, gnt, rv, rd, redir, rpc, rdy);
    checkModel(tag);
    advance();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    bit          en;
    bit          gnt;
    bit          rv;
    logic [31:0] rd;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input bit en, input bit gnt, input bit rv, input logic [31:0] rd,
                              input bit rdy, input bit e_req, input logic [31:0] e_addr,
                              input bit e_valid, input logic [31:0] e_instr,
                              input logic [31:0] e_pc);
    vec_t v;
    v = '{en, gnt, rv, rd, rdy, e_req, e_addr, e_valid, e_instr, e_pc};
    return v;
  endfunction

  vec_t tbl [12];

  bit          r_pending;
  int          r_delay;
  logic [31:0] waddrs[$];

  initial begin
    rst_in = 1'b1;
    w_en = 1'b0; w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
    fetch_en_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    redirect_i = 0; redirect_pc_i = 0; instr_ready_i = 0;
    r_pending = 0; r_delay = 0;

    tbl[0]  = mk(1, 0, 0, 32'h0,   0, 0, 32'h0, 0, NOP,           32'h0);
    tbl[1]  = mk(1, 0, 0, 32'h0,   0, 1, 32'h0, 0, NOP,           32'h0);
    tbl[2]  = mk(1, 1, 0, 32'h0,   0, 1, 32'h0, 0, NOP,           32'h0);
    tbl[3]  = mk(1, 0, 1, 32'h93,  0, 0, 32'h4, 0, NOP,           32'h0);
    tbl[4]  = mk(1, 0, 0, 32'h0,   0, 1, 32'h4, 1, 32'h0000_0093, 32'h0);
    tbl[5]  = mk(1, 1, 0, 32'h0,   0, 1, 32'h4, 1, 32'h0000_0093, 32'h0);
    tbl[6]  = mk(1, 0, 1, 32'h113, 0, 0, 32'h8, 1, 32'h0000_0093, 32'h0);
    tbl[7]  = mk(1, 0, 0, 32'h0,   0, 0, 32'h8, 1, 32'h0000_0093, 32'h0);
    tbl[8]  = mk(1, 0, 0, 32'h0,   1, 0, 32'h8, 1, 32'h0000_0093, 32'h0);
    tbl[9]  = mk(1, 1, 0, 32'h0,   0, 1, 32'h8, 1, 32'h0000_0113, 32'h4);
    tbl[10] = mk(1, 0, 1, 32'h193, 0, 0, 32'hC, 1, 32'h0000_0113, 32'h4);
    tbl[11] = mk(1, 0, 0, 32'h0,   1, 0, 32'hC, 1, 32'h0000_0113, 32'h4);

    // Reset state
    @(posedge clk_in); @(posedge clk_in); #1;
    checkOutput("reset", 0, 32'h0, 0, NOP, 32'h0);
    rst_in = 1'b0;
    modelReset(32'h0);

    // Table: basic fetch stream and back-pressure with a full queue
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].en, tbl[i].gnt, tbl[i].rv, tbl[i].rd, 1'b0, 32'h0, tbl[i].rdy);
      checkOutput($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                  tbl[i].e_instr, tbl[i].e_pc);
      checkModel($sformatf("vec%0d.model", i));
      advance();
    end

    // Redirect while waiting for a response
    stepSeq("s1", 1, 1, 0, 32'h0, 0, 32'h0, 0);
    stepSeq("s2", 1, 0, 0, 32'h0, 1, 32'h0000_0102, 0);
    applyStimulus(1, 0, 1, 32'hDEAD_BEEF, 0, 32'h0, 0);
    checkModel("s3");
    checkVal("flush_wait.valid", {31'd0, instr_valid_o}, 32'd0);
    checkVal("flush_wait.req", {31'd0, imem_req_o}, 32'd0);
    advance();
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
    checkModel("s4");
    checkVal("redir_wait.req", {31'd0, imem_req_o}, 32'd1);
    checkVal("redir_wait.addr", imem_addr_o, 32'h0000_0100);
    advance();
    stepSeq("s5", 1, 1, 0, 32'h0, 0, 32'h0, 0);
    stepSeq("s6", 1, 0, 1, 32'h0000_0513, 0, 32'h0, 0);

    // Redirect in the same cycle as the grant
    applyStimulus(1, 1, 0, 32'h0, 1, 32'h0000_0200, 0);
    checkModel("s7");
    checkVal("redir_gnt.head_instr", instr_o, 32'h0000_0513);
    checkVal("redir_gnt.head_pc", instr_pc_o, 32'h0000_0100);
    advance();
    stepSeq("s8", 1, 0, 1, 32'hBAD0_0BAD, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
    checkModel("s9");
    checkVal("redir_gnt.req", {31'd0, imem_req_o}, 32'd1);
    checkVal("redir_gnt.addr", imem_addr_o, 32'h0000_0200);
    checkVal("redir_gnt.valid", {31'd0, instr_valid_o}, 32'd0);
    advance();
    stepSeq("s10", 1, 1, 0, 32'h0, 0, 32'h0, 0);
    stepSeq("s11", 1, 0, 1, 32'h0000_0613, 0, 32'h0, 0);

    // fetch_en low: ungranted request holds, granted one completes
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
    checkModel("s12");
    checkVal("en_low.head_instr", instr_o, 32'h0000_0613);
    checkVal("en_low.head_pc", instr_pc_o, 32'h0000_0200);
    checkVal("en_low.req_held", {31'd0, imem_req_o}, 32'd1);
    advance();
    stepSeq("s13", 0, 1, 0, 32'h0, 0, 32'h0, 0);
    stepSeq("s14", 0, 0, 0, 32'h0, 0, 32'h0, 0);
    stepSeq("s15", 0, 0, 1, 32'h0000_0713, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
    checkModel("s16");
    checkVal("en_low.idle_req", {31'd0, imem_req_o}, 32'd0);
    checkVal("en_low.addr", imem_addr_o, 32'h0000_0208);
    advance();
    stepSeq("s17", 1, 0, 0, 32'h0, 0, 32'h0, 1);
    stepSeq("s18", 1, 1, 0, 32'h0, 0, 32'h0, 0);

    // Asynchronous reset in the middle of WAIT
    fetch_en_i = 1; imem_gnt_i = 0; imem_rvalid_i = 0; redirect_i = 0; instr_ready_i = 0;
    #2;
    rst_in = 1'b1;
    #1;
    checkOutput("async_reset", 0, 32'h0, 0, NOP, 32'h0);
    modelReset(32'h0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    stepSeq("late_rvalid", 0, 0, 1, 32'h0000_0813, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
    checkModel("after_late");
    checkVal("late_rvalid.valid", {31'd0, instr_valid_o}, 32'd0);
    advance();

    // Randomized traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      bit g;
      bit rv;
      bit sp;
      g  = m_req && ($urandom_range(0, 2) != 0);
      rv = r_pending && (r_delay == 0);
      sp = !m_req && !m_inflight && ($urandom_range(0, 19) == 0);
      applyStimulus($urandom_range(0, 3) != 0, g, rv || sp, $urandom,
                    $urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 1) == 1);
      checkModel($sformatf("rand%0d", c));
      if (rv) r_pending = 0;
      else if (r_pending && r_delay > 0) r_delay--;
      if (g) begin
        r_pending = 1;
        r_delay = $urandom_range(0, 2);
      end
      advance();
    end

    // Address wrap from a high reset PC
    fetch_en_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; redirect_i = 0;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    modelReset(32'h0);
    w_en = 1'b1;
    w_gnt = 1'b1;
    begin
      bit prev_gnt;
      prev_gnt = 0;
      for (int c = 0; c < 12 && waddrs.size() < 3; c++) begin
        w_rvalid = prev_gnt;
        w_rdata  = NOP;
        #4;
        prev_gnt = w_req;
        if (w_req) waddrs.push_back(w_addr);
        @(posedge clk_in); #1;
      end
    end
    checkVal("wrap.count", waddrs.size(), 32'd3);
    if (waddrs.size() >= 3) begin
      checkVal("wrap.addr0", waddrs[0], 32'hFFFF_FFF8);
      checkVal("wrap.addr1", waddrs[1], 32'hFFFF_FFFC);
      checkVal("wrap.addr2", waddrs[2], 32'h0000_0000);
    end
    w_en = 1'b0;
    w_gnt = 1'b0;
    w_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
